mc_load_store_unit: RTL and testbench

//  Multi-cycle load/store unit that replaces the single-cycle negedge DPI memory access in execute.

---
 rtl/mc_lsu_pkg.sv | 38 +++
 rtl/lsu_lane_align.sv | 61 ++++++
 rtl/mc_load_store_unit.sv | 195 +++++++++++++++++++
 tb/tb_mc_load_store_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_lsu_pkg.sv
// Shared encodings for the multi-cycle load/store unit: size codes, fault codes,
// FSM states and the byte-mask helper.
package mc_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // memop[2] selects zero-extension on loads
  localparam int unsigned MEMOP_UNSIGNED_BIT = 2;
  localparam logic [2:0]  MEMOP_D    = 3'b011;
  localparam logic [2:0]  MEMOP_WU   = 3'b110;
  localparam logic [2:0]  MEMOP_RSVD = 3'b111;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_BUS      = 2'd2;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP,
    ST_DONE
  } lsu_state_e;

  // Byte-enable pattern for an access of the given size at lane offset 0
  function automatic logic [7:0] lsu_size_mask(input logic [2:0] memop);
    case (memop[1:0])
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit: store strobe/data shift, load
// extract plus sign/zero extension, and alignment/legality decode.
module lsu_lane_align
  import mc_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        i_off,
  input  logic [2:0]        i_memop,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [XLEN/8-1:0] o_wstrb,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_misalign,
  output logic              o_illegal
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  logic [OFF_W-1:0] w_off;
  logic [OFF_W+2:0] w_shamt;
  logic [XLEN-1:0]  w_rsh;
  logic [1:0]       w_size;
  logic             w_signed;

  assign w_off    = i_off[OFF_W-1:0];
  assign w_shamt  = {w_off, 3'b000};
  assign w_size   = i_memop[1:0];
  assign w_signed = ~i_memop[MEMOP_UNSIGNED_BIT];

  assign o_wstrb = NB'(lsu_size_mask(i_memop)) << w_off;
  assign o_wdata = i_wdata << w_shamt;
  assign w_rsh   = i_rdata >> w_shamt;

  // Extension is built at 64 bits and truncated so XLEN=32 needs no special case
  always_comb begin
    o_rdata = w_rsh;
    case (w_size)
      SZ_B:    o_rdata = XLEN'({{56{w_signed & w_rsh[7]}},  w_rsh[7:0]});
      SZ_H:    o_rdata = XLEN'({{48{w_signed & w_rsh[15]}}, w_rsh[15:0]});
      SZ_W:    o_rdata = XLEN'({{32{w_signed & w_rsh[31]}}, w_rsh[31:0]});
      default: o_rdata = w_rsh;
    endcase
  end

  always_comb begin
    o_misalign = 1'b0;
    case (w_size)
      SZ_H:    o_misalign = i_off[0];
      SZ_W:    o_misalign = |i_off[1:0];
      SZ_D:    o_misalign = |i_off;
      default: o_misalign = 1'b0;
    endcase
  end

  assign o_illegal = (i_memop == MEMOP_RSVD) ||
                     ((XLEN == 32) && ((i_memop == MEMOP_D) || (i_memop == MEMOP_WU)));

endmodule

// File: rtl/mc_load_store_unit.sv
// Multi-cycle load/store unit: accepts one op from execute, issues at most one
// aligned bus request, and returns load data, passthrough value or a fault.
module mc_load_store_unit
  import mc_lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic              in_we,
  input  logic              in_re,
  input  logic [2:0]        in_memop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [1:0]        out_fault,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wstrb,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [XLEN-1:0]   mem_rsp_data,
  input  logic              mem_rsp_err
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e       r_state, w_state_nxt;
  logic [2:0]       r_off, w_off_nxt;
  logic [2:0]       r_memop, w_memop_nxt;
  logic             r_we, w_we_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_in_ready, r_out_valid;
  logic [XLEN-1:0]  r_out_data, w_out_data_nxt;
  logic [1:0]       r_out_fault, w_out_fault_nxt;
  logic             r_req_valid, w_req_valid_nxt;
  logic [XLEN-1:0]  r_req_addr, w_req_addr_nxt;
  logic             r_req_we, w_req_we_nxt;
  logic [XLEN-1:0]  r_req_wdata, w_req_wdata_nxt;
  logic [NB-1:0]    r_req_wstrb, w_req_wstrb_nxt;

  logic [2:0]       w_la_off;
  logic [2:0]       w_la_memop;
  logic [NB-1:0]    w_wstrb;
  logic [XLEN-1:0]  w_wdata;
  logic [XLEN-1:0]  w_rdata;
  logic             w_misalign;
  logic             w_illegal;

  // Decode the incoming op while idle, the latched op otherwise
  assign w_la_off   = (r_state == ST_IDLE) ? in_addr[2:0] : r_off;
  assign w_la_memop = (r_state == ST_IDLE) ? in_memop     : r_memop;

  lsu_lane_align #(
    .XLEN (XLEN)
  ) u_lane_align (
    .i_off      (w_la_off),
    .i_memop    (w_la_memop),
    .i_wdata    (in_wdata),
    .i_rdata    (mem_rsp_data),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_off_nxt       = r_off;
    w_memop_nxt     = r_memop;
    w_we_nxt        = r_we;
    w_cnt_nxt       = r_cnt;
    w_out_data_nxt  = r_out_data;
    w_out_fault_nxt = r_out_fault;
    w_req_valid_nxt = r_req_valid;
    w_req_addr_nxt  = r_req_addr;
    w_req_we_nxt    = r_req_we;
    w_req_wdata_nxt = r_req_wdata;
    w_req_wstrb_nxt = r_req_wstrb;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_off_nxt       = in_addr[2:0];
          w_memop_nxt     = in_memop;
          w_we_nxt        = in_we;
          w_out_data_nxt  = '0;
          w_out_fault_nxt = FAULT_NONE;
          w_state_nxt     = ST_DONE;
          if (!in_we && !in_re) begin
            w_out_data_nxt = in_addr;
          end else if ((in_we && in_re) || w_illegal) begin
            w_out_fault_nxt = FAULT_TIMEOUT;
          end else if (w_misalign) begin
            w_out_fault_nxt = FAULT_MISALIGN;
          end else begin
            w_state_nxt     = ST_REQ;
            w_req_valid_nxt = 1'b1;
            w_req_addr_nxt  = {in_addr[XLEN-1:OFF_W], OFF_W'(0)};
            w_req_we_nxt    = in_we;
            w_req_wdata_nxt = in_we ? w_wdata : '0;
            w_req_wstrb_nxt = in_we ? w_wstrb : '0;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          w_req_valid_nxt = 1'b0;
          w_cnt_nxt       = '0;
          w_state_nxt     = ST_RSP;
        end
      end
      ST_RSP: begin
        // A response in the same cycle as the timeout wins
        if (mem_rsp_valid) begin
          w_state_nxt = ST_DONE;
          if (mem_rsp_err) begin
            w_out_fault_nxt = FAULT_BUS;
          end else if (!r_we) begin
            w_out_data_nxt = w_rdata;
          end
        end else if ((TIMEOUT != 0) && ((32'(r_cnt) + 32'd1) == TIMEOUT)) begin
          w_state_nxt     = ST_DONE;
          w_out_fault_nxt = FAULT_TIMEOUT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt     = ST_IDLE;
          w_out_data_nxt  = '0;
          w_out_fault_nxt = FAULT_NONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_off       <= '0;
      r_memop     <= '0;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_fault <= FAULT_NONE;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_we    <= 1'b0;
      r_req_wdata <= '0;
      r_req_wstrb <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_off       <= w_off_nxt;
      r_memop     <= w_memop_nxt;
      r_we        <= w_we_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      r_out_data  <= w_out_data_nxt;
      r_out_fault <= w_out_fault_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_req_we    <= w_req_we_nxt;
      r_req_wdata <= w_req_wdata_nxt;
      r_req_wstrb <= w_req_wstrb_nxt;
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_fault     = r_out_fault;
  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;
  assign mem_req_we    = r_req_we;
  assign mem_req_wdata = r_req_wdata;
  assign mem_req_wstrb = r_req_wstrb;
  assign mem_rsp_ready = 1'b1;

endmodule

// File: tb/tb_mc_load_store_unit.sv
// Directed bench for mc_load_store_unit: a 32-bit instance with a short watchdog
// and a 64-bit instance, both checked against hand-computed values.
module tb_mc_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 32-bit instance, TIMEOUT=4
  logic        a_in_valid, a_in_ready, a_in_we, a_in_re;
  logic [31:0] a_in_addr, a_in_wdata, a_out_data, a_mem_req_addr, a_mem_req_wdata, a_mem_rsp_data;
  logic [2:0]  a_in_memop;
  logic        a_out_valid, a_out_ready;
  logic [1:0]  a_out_fault;
  logic        a_mem_req_valid, a_mem_req_ready, a_mem_req_we;
  logic [3:0]  a_mem_req_wstrb;
  logic        a_mem_rsp_valid, a_mem_rsp_ready, a_mem_rsp_err;

  // 64-bit instance, default watchdog
  logic        b_in_valid, b_in_ready, b_in_we, b_in_re;
  logic [63:0] b_in_addr, b_in_wdata, b_out_data, b_mem_req_addr, b_mem_req_wdata, b_mem_rsp_data;
  logic [2:0]  b_in_memop;
  logic        b_out_valid, b_out_ready;
  logic [1:0]  b_out_fault;
  logic        b_mem_req_valid, b_mem_req_ready, b_mem_req_we;
  logic [7:0]  b_mem_req_wstrb;
  logic        b_mem_rsp_valid, b_mem_rsp_ready, b_mem_rsp_err;

  mc_load_store_unit #(.XLEN(32), .TIMEOUT(4)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_addr(a_in_addr), .in_wdata(a_in_wdata),
    .in_we(a_in_we), .in_re(a_in_re), .in_memop(a_in_memop),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_fault(a_out_fault),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready), .mem_req_addr(a_mem_req_addr),
    .mem_req_we(a_mem_req_we), .mem_req_wdata(a_mem_req_wdata), .mem_req_wstrb(a_mem_req_wstrb),
    .mem_rsp_valid(a_mem_rsp_valid), .mem_rsp_ready(a_mem_rsp_ready), .mem_rsp_data(a_mem_rsp_data),
    .mem_rsp_err(a_mem_rsp_err)
  );

  mc_load_store_unit #(.XLEN(64), .TIMEOUT(255)) u_dut64 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_addr(b_in_addr), .in_wdata(b_in_wdata),
    .in_we(b_in_we), .in_re(b_in_re), .in_memop(b_in_memop),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_fault(b_out_fault),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_req_addr(b_mem_req_addr),
    .mem_req_we(b_mem_req_we), .mem_req_wdata(b_mem_req_wdata), .mem_req_wstrb(b_mem_req_wstrb),
    .mem_rsp_valid(b_mem_rsp_valid), .mem_rsp_ready(b_mem_rsp_ready), .mem_rsp_data(b_mem_rsp_data),
    .mem_rsp_err(b_mem_rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc32(input logic we, input logic re, input logic [2:0] memop,
                       input logic [31:0] addr, input logic [31:0] wdata);
    a_in_valid = 1'b1; a_in_we = we; a_in_re = re; a_in_memop = memop;
    a_in_addr = addr; a_in_wdata = wdata;
    tick();
    a_in_valid = 1'b0;
  endtask

  // Zero-wait bus: grant the request, then respond on the next cycle
  task automatic bus32(input logic [31:0] rdata, input logic err);
    a_mem_req_ready = 1'b1;
    tick();
    a_mem_req_ready = 1'b0;
    a_mem_rsp_valid = 1'b1; a_mem_rsp_data = rdata; a_mem_rsp_err = err;
    tick();
    a_mem_rsp_valid = 1'b0; a_mem_rsp_err = 1'b0;
  endtask

  task automatic take32(input string tag, input logic [31:0] data, input logic [1:0] fault);
    chk({tag, "_valid"}, a_out_valid, 1'b1);
    chk({tag, "_data"},  a_out_data, data);
    chk({tag, "_fault"}, a_out_fault, fault);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk({tag, "_idle"}, a_in_ready, 1'b1);
  endtask

  task automatic acc64(input logic we, input logic re, input logic [2:0] memop,
                       input logic [63:0] addr, input logic [63:0] wdata);
    b_in_valid = 1'b1; b_in_we = we; b_in_re = re; b_in_memop = memop;
    b_in_addr = addr; b_in_wdata = wdata;
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic bus64(input logic [63:0] rdata);
    b_mem_req_ready = 1'b1;
    tick();
    b_mem_req_ready = 1'b0;
    b_mem_rsp_valid = 1'b1; b_mem_rsp_data = rdata;
    tick();
    b_mem_rsp_valid = 1'b0;
  endtask

  task automatic take64(input string tag, input logic [63:0] data, input logic [1:0] fault);
    chk({tag, "_valid"}, b_out_valid, 1'b1);
    chk({tag, "_data"},  b_out_data, data);
    chk({tag, "_fault"}, b_out_fault, fault);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_we = 0; a_in_re = 0; a_in_memop = 0; a_in_addr = 0; a_in_wdata = 0;
    a_out_ready = 0; a_mem_req_ready = 0; a_mem_rsp_valid = 0; a_mem_rsp_data = 0; a_mem_rsp_err = 0;
    b_in_valid = 0; b_in_we = 0; b_in_re = 0; b_in_memop = 0; b_in_addr = 0; b_in_wdata = 0;
    b_out_ready = 0; b_mem_req_ready = 0; b_mem_rsp_valid = 0; b_mem_rsp_data = 0; b_mem_rsp_err = 0;
    tick();
    tick();
    chk("rst_in_ready",  a_in_ready, 1'b1);
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_out_data",  a_out_data, 32'h0);
    chk("rst_out_fault", a_out_fault, 2'd0);
    chk("rst_req_valid", a_mem_req_valid, 1'b0);
    chk("rst_rsp_ready", a_mem_rsp_ready, 1'b1);
    chk("rst64_in_ready", b_in_ready, 1'b1);
    rst = 1'b0;

    // Halfword store at offset 2, with the bus stalling one cycle
    acc32(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'hAABB_CCDD);
    chk("sh_req_valid", a_mem_req_valid, 1'b1);
    chk("sh_in_ready",  a_in_ready, 1'b0);
    tick();
    chk("sh_hold_valid", a_mem_req_valid, 1'b1);
    chk("sh_addr",  a_mem_req_addr, 32'h8000_0000);
    chk("sh_we",    a_mem_req_we, 1'b1);
    chk("sh_wstrb", a_mem_req_wstrb, 4'b1100);
    chk("sh_wdata", a_mem_req_wdata, 32'hCCDD_0000);
    bus32(32'h1234_5678, 1'b0);
    take32("sh", 32'h0, 2'd0);

    // Signed and unsigned byte loads from the top lane
    acc32(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0);
    chk("lb_addr",  a_mem_req_addr, 32'h8000_0000);
    chk("lb_we",    a_mem_req_we, 1'b0);
    chk("lb_wstrb", a_mem_req_wstrb, 4'b0000);
    bus32(32'h80FF_0102, 1'b0);
    take32("lb", 32'hFFFF_FF80, 2'd0);
    acc32(1'b0, 1'b1, 3'b100, 32'h8000_0003, 32'h0);
    bus32(32'h80FF_0102, 1'b0);
    take32("lbu", 32'h0000_0080, 2'd0);

    // Misaligned word: fault after one cycle, never reaches the bus
    acc32(1'b0, 1'b1, 3'b010, 32'h8000_0001, 32'h0);
    chk("lw_mis_noreq", a_mem_req_valid, 1'b0);
    take32("lw_mis", 32'h0, 2'd1);

    // Load and store both set, then a doubleword memop on a 32-bit unit
    acc32(1'b1, 1'b1, 3'b010, 32'h8000_0000, 32'h0);
    chk("werr_noreq", a_mem_req_valid, 1'b0);
    take32("werr", 32'h0, 2'd3);
    acc32(1'b0, 1'b1, 3'b011, 32'h8000_0000, 32'h0);
    take32("ld32_ill", 32'h0, 2'd3);

    // Passthrough: one-cycle latency, no accept while the result is pending
    acc32(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0);
    chk("pass_in_ready", a_in_ready, 1'b0);
    chk("pass_noreq", a_mem_req_valid, 1'b0);
    take32("pass", 32'h1234_5678, 2'd0);

    // Bus never responds: fault 3 on the fourth cycle in RSP
    acc32(1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'h0);
    a_mem_req_ready = 1'b1;
    tick();
    a_mem_req_ready = 1'b0;
    tick(); tick(); tick();
    chk("tmo_early", a_out_valid, 1'b0);
    tick();
    take32("tmo", 32'h0, 2'd3);

    // Response landing on the timeout cycle still wins
    acc32(1'b0, 1'b1, 3'b010, 32'h8000_0010, 32'h0);
    a_mem_req_ready = 1'b1;
    tick();
    a_mem_req_ready = 1'b0;
    tick(); tick(); tick();
    a_mem_rsp_valid = 1'b1; a_mem_rsp_data = 32'h0102_0304;
    tick();
    a_mem_rsp_valid = 1'b0;
    take32("tmo_race", 32'h0102_0304, 2'd0);

    // Bus error
    acc32(1'b0, 1'b1, 3'b010, 32'h8000_0008, 32'h0);
    bus32(32'hDEAD_BEEF, 1'b1);
    take32("buserr", 32'h0, 2'd2);

    // Writeback back-pressure holds the result
    acc32(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0);
    bus32(32'h8001_7777, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", a_out_valid, 1'b1);
      chk("hold_data",  a_out_data, 32'hFFFF_8001);
      chk("hold_in_ready", a_in_ready, 1'b0);
      tick();
    end
    take32("lh", 32'hFFFF_8001, 2'd0);

    // Reset while waiting for a response, then a stale response is dropped
    acc32(1'b0, 1'b1, 3'b010, 32'h8000_0008, 32'h0);
    a_mem_req_ready = 1'b1;
    tick();
    a_mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrsp_in_ready", a_in_ready, 1'b1);
    chk("rstrsp_out_valid", a_out_valid, 1'b0);
    a_mem_rsp_valid = 1'b1; a_mem_rsp_data = 32'h1111_1111;
    tick();
    a_mem_rsp_valid = 1'b0;
    chk("stale_out_valid", a_out_valid, 1'b0);
    chk("stale_in_ready", a_in_ready, 1'b1);
    chk("stale_req_valid", a_mem_req_valid, 1'b0);
    acc32(1'b0, 1'b0, 3'b000, 32'hCAFE_F00D, 32'h0);
    take32("post_rst", 32'hCAFE_F00D, 2'd0);

    // 64-bit: doubleword load, word loads from the upper lane, word store
    acc64(1'b0, 1'b1, 3'b011, 64'h8000_0008, 64'h0);
    chk("ld64_addr", b_mem_req_addr, 64'h8000_0008);
    chk("ld64_wstrb", b_mem_req_wstrb, 8'h00);
    bus64(64'h8000_0000_0000_0001);
    take64("ld64", 64'h8000_0000_0000_0001, 2'd0);
    acc64(1'b0, 1'b1, 3'b110, 64'h8000_000C, 64'h0);
    chk("lwu64_addr", b_mem_req_addr, 64'h8000_0008);
    bus64(64'h8000_0000_0000_0001);
    take64("lwu64", 64'h0000_0000_8000_0000, 2'd0);
    acc64(1'b0, 1'b1, 3'b010, 64'h8000_000C, 64'h0);
    bus64(64'h8000_0000_0000_0001);
    take64("lw64", 64'hFFFF_FFFF_8000_0000, 2'd0);
    acc64(1'b1, 1'b0, 3'b010, 64'h8000_0004, 64'h1122_3344);
    chk("sw64_addr",  b_mem_req_addr, 64'h8000_0000);
    chk("sw64_wstrb", b_mem_req_wstrb, 8'hF0);
    chk("sw64_wdata", b_mem_req_wdata, 64'h1122_3344_0000_0000);
    bus64(64'h0);
    take64("sw64", 64'h0, 2'd0);
    acc64(1'b0, 1'b1, 3'b011, 64'h8000_0004, 64'h0);
    chk("ld64_mis_noreq", b_mem_req_valid, 1'b0);
    take64("ld64_mis", 64'h0, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
